// File: rtl/entity_slot_scheduler_if.sv
// Requester-side write bus for the entity slot scheduler.
// Requester i drives req_slot[4i+3:4i] and req_data[14i+13:14i]; req_ready is a one-hot grant.
interface entity_slot_scheduler_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*4-1:0]  req_slot;
  logic [NUM_REQ*14-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;

  modport master (output req_valid, req_slot, req_data, input req_ready);
  modport slave  (input req_valid, req_slot, req_data, output req_ready);
endinterface

// File: rtl/entity_slot_scheduler.sv
// Round-robin writes from game-logic requesters into a shadow slot bank,
// copied to the PPU-facing active bank once per frame.
module entity_slot_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_SLOTS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_end,
  input  logic                      freeze,
  input  logic                      clear_all,
  entity_slot_scheduler_if.slave    req,
  output logic [NUM_SLOTS*14-1:0]   active_slots,
  output logic                      commit_done,
  output logic                      dirty,
  output logic                      slot_err
);
  localparam int          PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [13:0] EMPTY      = 14'h3C00;
  localparam logic [4:0]  SLOT_LIMIT = 5'(NUM_SLOTS);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_CLEAR  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]       state;
  logic [PTR_W-1:0] ptr;
  logic             pending;
  logic [13:0]      shadow [NUM_SLOTS];
  logic [13:0]      active [NUM_SLOTS];

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   cand;
  logic               xfer;
  logic [3:0]         wr_slot;
  logic [13:0]        wr_data;
  logic               wr_bad;
  logic               fe_ok;
  logic [PTR_W-1:0]   ptr_next;

  // Grants only in RUN and never while reset is held low.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    cand    = '0;
    xfer    = 1'b0;
    if (reset && state == S_RUN) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        cand = PTR_W'((32'(ptr) + off) % NUM_REQ);
        if (!xfer && req.req_valid[cand]) begin
          xfer        = 1'b1;
          gnt_idx     = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

  assign req.req_ready = grant;
  assign wr_slot  = req.req_slot[gnt_idx*4 +: 4];
  assign wr_data  = req.req_data[gnt_idx*14 +: 14];
  assign wr_bad   = {1'b0, wr_slot} >= SLOT_LIMIT;
  assign fe_ok    = frame_end & ~freeze;
  assign ptr_next = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_RUN;
      ptr         <= '0;
      pending     <= 1'b0;
      commit_done <= 1'b0;
      dirty       <= 1'b0;
      slot_err    <= 1'b0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
        shadow[k] <= EMPTY;
        active[k] <= EMPTY;
      end
    end else begin
      commit_done <= (state == S_COMMIT);
      slot_err    <= xfer & wr_bad;
      if (xfer) ptr <= ptr_next;
      if (xfer && !wr_bad) begin
        dirty <= 1'b1;
        for (int unsigned k = 0; k < NUM_SLOTS; k++)
          if (wr_slot == 4'(k)) shadow[k] <= wr_data;
      end
      case (state)
        S_RUN: begin
          if (clear_all) begin
            state   <= S_CLEAR;
            pending <= fe_ok;
          end else if (fe_ok) begin
            state <= S_COMMIT;
          end
        end
        S_CLEAR: begin
          // A frame_end arriving during the clear still commits right after it.
          for (int unsigned k = 0; k < NUM_SLOTS; k++) shadow[k] <= EMPTY;
          dirty   <= 1'b1;
          state   <= (pending || fe_ok) ? S_COMMIT : S_RUN;
          pending <= 1'b0;
        end
        S_COMMIT: begin
          for (int unsigned k = 0; k < NUM_SLOTS; k++) active[k] <= shadow[k];
          dirty <= 1'b0;
          state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  always_comb begin
    active_slots = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++)
      active_slots[k*14 +: 14] = active[k];
  end
endmodule
